// File: rtl/debug_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_tx_scheduler_if
//  Description : Bundle between the telemetry requesters / debug uart_tx and
//                the debug packet scheduler.
//                master = scheduler side, slave = requesters + uart_tx side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_tx_scheduler_if;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic         tx_send;
    logic [7:0]   tx_byte;
    logic         busy;
    logic [15:0]  pkt_count;

    modport master (
        input  req,
        input  req_data,
        output ack,
        output tx_send,
        output tx_byte,
        output busy,
        output pkt_count
    );

    modport slave (
        output req,
        output req_data,
        input  ack,
        input  tx_send,
        input  tx_byte,
        input  busy,
        input  pkt_count
    );
endinterface
`default_nettype wire

// File: rtl/debug_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : debug_tx_scheduler
//  Description : Round-robin scheduler sharing the debug uart_tx among four
//                telemetry sources. Each grant latches a 32-bit word and sends
//                it as a 7-byte packet: SYNC, ID, D3..D0, XOR checksum. Bytes
//                are paced by a byte-period timer because uart_tx has no busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_tx_scheduler #(
    parameter int         CLKS_PER_BIT = 40,
    parameter int         GAP_CLKS     = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    debug_tx_scheduler_if.master bus
);

    localparam int BYTE_CLKS = 10 * CLKS_PER_BIT + GAP_CLKS;
    localparam int TMR_W     = $clog2(BYTE_CLKS);
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_last;
    logic [1:0]         r_grant;
    logic [1:0]         w_pick;
    logic               w_found;
    logic [31:0]        r_word;
    logic [2:0]         r_index;
    logic [2:0]         w_idx_next;
    logic [TMR_W-1:0]   r_timer;
    logic [7:0]         r_tx_byte;
    logic [7:0]         r_chk;
    logic [7:0]         w_byte;
    logic [15:0]        r_pkt_count;
    logic               w_timer_expire;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int i = 1; i <= 4; i++) begin
            if (!w_found && bus.req[r_last + 2'(i)]) begin
                w_found = 1'b1;
                w_pick  = r_last + 2'(i);
            end
        end
    end

    // The decremented timer reaching zero ends the byte period, so sends are
    // exactly BYTE_CLKS apart (SEND cycle plus BYTE_CLKS-1 WAIT cycles).
    assign w_timer_expire = (r_timer == TMR_W'(1));
    assign w_idx_next     = r_index + 3'd1;

    // Byte that will be issued at the next SEND; index 6 is the running XOR.
    always_comb begin
        w_byte = r_chk;
        case (w_idx_next)
            3'd1:    w_byte = {6'b0, r_grant};
            3'd2:    w_byte = r_word[31:24];
            3'd3:    w_byte = r_word[23:16];
            3'd4:    w_byte = r_word[15:8];
            3'd5:    w_byte = r_word[7:0];
            default: w_byte = r_chk;
        endcase
    end

    // Next-state logic of the packet sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_GRANT;
            S_GRANT: w_state_next = S_SEND;
            S_SEND:  w_state_next = S_WAIT;
            S_WAIT:  if (w_timer_expire)
                         w_state_next = (r_index == LAST_IDX) ? S_DONE : S_SEND;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Datapath: arbitration pointer, word latch, byte index, timer, checksum.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last      <= 2'd3;
            r_grant     <= 2'd0;
            r_word      <= 32'd0;
            r_index     <= 3'd0;
            r_timer     <= '0;
            r_tx_byte   <= 8'd0;
            r_chk       <= 8'd0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                    end
                end
                S_GRANT: begin
                    r_word    <= bus.req_data[{r_grant, 5'b0} +: 32];
                    r_index   <= 3'd0;
                    r_chk     <= 8'd0;
                    r_tx_byte <= SYNC_BYTE;
                end
                S_SEND: begin
                    r_timer <= TMR_W'(BYTE_CLKS - 1);
                end
                S_WAIT: begin
                    r_timer <= r_timer - TMR_W'(1);
                    if (w_timer_expire && r_index != LAST_IDX) begin
                        r_index   <= w_idx_next;
                        r_tx_byte <= w_byte;
                        if (w_idx_next != LAST_IDX) r_chk <= r_chk ^ w_byte;
                    end
                end
                S_DONE: begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack       = (r_state == S_GRANT) ? (4'b0001 << r_grant) : 4'b0000;
    assign bus.tx_send   = (r_state == S_SEND);
    assign bus.tx_byte   = r_tx_byte;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_tx_scheduler
//  Description : Directed + randomized bench for debug_tx_scheduler with a
//                round-robin / packet-format reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_tx_scheduler;

    localparam int CPB = 4;
    localparam int GAP = 2;
    localparam int B   = 10 * CPB + GAP;   // 42

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_v   = 4'b0;
    logic [31:0] data_v [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_last   = 3;
    int m_pkts   = 0;
    int done_cyc = 0;
    int ack_cyc  = 0;

    debug_tx_scheduler_if bus ();

    assign bus.req      = req_v;
    assign bus.req_data = {data_v[3], data_v[2], data_v[1], data_v[0]};

    debug_tx_scheduler #(
        .CLKS_PER_BIT (CPB),
        .GAP_CLKS     (GAP),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Invariants checked every cycle.
    always @(negedge clock) begin
        chk("ack_onehot", 32'($countones(bus.ack) <= 1), 32'd1);
        chk("ack_send_excl", 32'((bus.ack != 4'b0) && bus.tx_send), 32'd0);
    end

    // Reference arbiter: first requesting source after the last grant.
    function automatic int rr_pick(input int last, input logic [3:0] m);
        for (int i = 1; i <= 4; i++)
            if (m[(last + i) % 4]) return (last + i) % 4;
        return 0;
    endfunction

    // Follow one whole packet: grant, 7 bytes at BYTE_CLKS spacing, DONE, IDLE.
    task automatic packet(input bit drop_req, input int glitch_src);
        int n;
        int src;
        logic [31:0] w;
        logic [7:0]  eb [7];
        src = rr_pick(m_last, req_v);
        n = 0;
        while (bus.ack === 4'b0 && n < 20) begin
            tick();
            n++;
        end
        ack_cyc = cyc;
        chk("ack", 32'(bus.ack), 32'(1) << src);
        chk("busy_grant", 32'(bus.busy), 32'd1);
        m_last = src;
        w = data_v[src];
        eb[0] = 8'hA5;
        eb[1] = 8'(src);
        eb[2] = w[31:24];
        eb[3] = w[23:16];
        eb[4] = w[15:8];
        eb[5] = w[7:0];
        eb[6] = eb[1] ^ eb[2] ^ eb[3] ^ eb[4] ^ eb[5];
        if (drop_req) req_v[src] = 1'b0;
        tick();
        data_v[src] = $urandom();          // changed one cycle after ack
        if (glitch_src >= 0) req_v[glitch_src] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                n = 0;
                repeat (B - 1) begin
                    tick();
                    if (bus.tx_send) n++;
                end
                chk("gap_sends", 32'(n), 32'd0);
                chk("byte_hold", 32'(bus.tx_byte), 32'(eb[k-1]));
                tick();
            end
            if (k == 2 && glitch_src >= 0) req_v[glitch_src] = 1'b0;
            chk("tx_send", 32'(bus.tx_send), 32'd1);
            chk($sformatf("byte%0d_src%0d", k, src), 32'(bus.tx_byte), 32'(eb[k]));
        end
        tick(B);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_nosend", 32'(bus.tx_send), 32'd0);
        done_cyc = cyc;
        tick();
        m_pkts = (m_pkts + 1) % 65536;
        chk("pkt_count", 32'(bus.pkt_count), 32'(m_pkts));
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int c0;
        int n;
        int sends;
        int prev_done;
        logic [3:0] m;

        for (int i = 0; i < 4; i++) data_v[i] = 32'd0;

        // ---- reset state
        tick(3);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_send", 32'(bus.tx_send), 32'd0);
        chk("rst_byte", 32'(bus.tx_byte), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.pkt_count), 32'd0);
        reset_n = 1'b1;
        m_last = 3;
        m_pkts = 0;
        tick(2);

        // ---- single request, source 2
        data_v[2] = 32'h12345678;
        req_v = 4'b0100;
        c0 = cyc;
        tick();
        chk("req_to_ack", 32'(cyc - c0), 32'd1);
        packet(1'b1, -1);

        // ---- all four held, distinct words: order 0,1,2,3,0
        for (int i = 0; i < 4; i++) data_v[i] = 32'h1111_1111 * (i + 1) ^ $urandom();
        m_last = 3;
        tick();
        // pointer in the DUT is 2 after the first packet; re-align by serving 3 alone
        req_v = 4'b1000;
        packet(1'b1, -1);
        req_v = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            prev_done = done_cyc;
            packet(1'b0, -1);
            if (p > 0) chk("done_to_ack", 32'(ack_cyc - prev_done), 32'd2);
        end
        req_v = 4'b0000;

        // ---- request withdrawn during a packet for source 0
        tick(3);
        req_v = 4'b0001;
        packet(1'b1, 1);
        n = 0;
        repeat (60) begin
            tick();
            if (bus.ack != 4'b0 || bus.busy) n++;
        end
        chk("no_stale_grant", 32'(n), 32'd0);

        // ---- randomized requests against the model
        for (int it = 0; it < 10; it++) begin
            m = 4'($urandom_range(0, 15));
            for (int s = 0; s < 4; s++)
                if (m[s] && !req_v[s]) data_v[s] = $urandom();
            req_v = req_v | m;
            if (req_v == 4'b0) begin
                req_v[it % 4] = 1'b1;
            end
            packet(1'b1, -1);
        end
        n = 0;
        while (req_v != 4'b0 && n < 4) begin
            packet(1'b1, -1);
            n++;
        end

        // ---- reset mid-packet
        tick(2);
        data_v[2] = $urandom();
        req_v = 4'b0100;
        n = 0;
        while (bus.ack === 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_test_ack", 32'(bus.ack), 32'b0100);
        req_v = 4'b0;
        sends = 0;
        n = 0;
        while (sends < 3 && n < 400) begin
            tick();
            if (bus.tx_send) sends++;
            n++;
        end
        chk("third_send_seen", 32'(sends), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        chk("mid_rst_send", 32'(bus.tx_send), 32'd0);
        chk("mid_rst_byte", 32'(bus.tx_byte), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_count", 32'(bus.pkt_count), 32'd0);
        m_pkts = 0;
        m_last = 3;
        tick(2);
        reset_n = 1'b1;
        n = 0;
        repeat (3 * B) begin
            tick();
            if (bus.tx_send) n++;
        end
        chk("no_resume", 32'(n), 32'd0);
        data_v[0] = $urandom();
        data_v[3] = $urandom();
        req_v = 4'b1001;
        packet(1'b1, -1);
        packet(1'b1, -1);

        // ---- counter wrap
        tick(2);
        force dut.r_pkt_count = 16'hFFFF;
        tick();
        release dut.r_pkt_count;
        tick();
        chk("count_preset", 32'(bus.pkt_count), 32'h0000FFFF);
        m_pkts = 16'hFFFF;
        data_v[1] = $urandom();
        req_v = 4'b0010;
        packet(1'b1, -1);
        chk("count_wrapped", 32'(bus.pkt_count), 32'd0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
